game_level_ctrl: RTL and testbench

- Game-flow controller that sequences the game clock divider.
- Owns the divider's enable and speed-select inputs.
- Tracks game ticks, advances difficulty level every TICKS_PER_LEVEL ticks, and handles start, pause and game-over.
- Guarantees a clean reload window whenever the speed changes, because the divider only latches a new period while disabled.

---
 rtl/game_level_ctrl_if.sv | 29 ++
 rtl/game_level_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_game_level_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/game_level_ctrl_if.sv
// game_level_ctrl_if
// Bundles the game-flow controller's control and status signals.
//   master : game side / testbench - drives buttons, game_over and game_tick,
//            observes divider controls and status.
//   slave  : controller - consumes those inputs and drives clk_enable, speed,
//            level, tick_cnt, level_up and state.
// Clock and reset are kept as plain ports on the controller.
interface game_level_ctrl_if;
    logic       start_btn;
    logic       pause_btn;
    logic       game_over;
    logic       game_tick;
    logic       clk_enable;
    logic [2:0] speed;
    logic [1:0] level;
    logic [7:0] tick_cnt;
    logic       level_up;
    logic [2:0] state;

    modport master (
        output start_btn, pause_btn, game_over, game_tick,
        input  clk_enable, speed, level, tick_cnt, level_up, state
    );

    modport slave (
        input  start_btn, pause_btn, game_over, game_tick,
        output clk_enable, speed, level, tick_cnt, level_up, state
    );
endinterface

// File: rtl/game_level_ctrl.sv
// game_level_ctrl
// Game-flow controller sequencing an external game clock divider. Counts
// divider ticks, advances the difficulty level every TICKS_PER_LEVEL ticks,
// and handles start, pause and game-over. Because the divider only latches a
// new period while disabled, every speed change is followed by a window with
// clk_enable low before running again.
// Ports:
//   in_clk : system clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of game_level_ctrl_if
//            in : start_btn, pause_btn, game_over, game_tick
//            out: clk_enable, speed, level, tick_cnt, level_up, state
//
// state  | meaning
// IDLE   | after reset, divider off, waiting for start
// RELOAD | divider off for RELOAD_CYCLES so it latches the new speed
// RUN    | divider on, ticks counted
// PAUSE  | divider off, level/tick_cnt held
// OVER   | divider off, score frozen until restart
module game_level_ctrl #(
    parameter int TICKS_PER_LEVEL = 32,
    parameter int RELOAD_CYCLES   = 2,
    parameter int MAX_LEVEL       = 3
) (
    input  logic               in_clk,
    input  logic               rst_n,
    game_level_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RELOAD = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam int         RW      = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam logic [RW-1:0] RL_LOAD = RW'(RELOAD_CYCLES - 1);
    localparam logic [7:0] TC_LAST = 8'(TICKS_PER_LEVEL - 1);
    localparam logic [1:0] MAXL    = 2'(MAX_LEVEL);

    state_t        st;
    logic          clk_enable;
    logic [2:0]    speed;
    logic [1:0]    level;
    logic [7:0]    tick_cnt;
    logic          level_up;
    logic          start_d;
    logic          pause_d;
    logic          tick_d;
    logic [RW-1:0] rl_cnt;

    logic start_rise;
    logic pause_rise;
    logic tick;

    assign start_rise = bus.start_btn & ~start_d;
    assign pause_rise = bus.pause_btn & ~pause_d;
    assign tick       = bus.game_tick ^ tick_d;

    // Higher level -> faster divider; one-hot-ish encoding owned by the divider.
    function automatic logic [2:0] speed_of(input logic [1:0] lvl);
        case (lvl)
            2'd0:    speed_of = 3'b000;
            2'd1:    speed_of = 3'b100;
            2'd2:    speed_of = 3'b010;
            default: speed_of = 3'b001;
        endcase
    endfunction

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            clk_enable <= 1'b0;
            speed      <= 3'b000;
            level      <= 2'd0;
            tick_cnt   <= 8'd0;
            level_up   <= 1'b0;
            start_d    <= 1'b0;
            pause_d    <= 1'b0;
            tick_d     <= 1'b0;
            rl_cnt     <= '0;
        end else begin
            start_d  <= bus.start_btn;
            pause_d  <= bus.pause_btn;
            tick_d   <= bus.game_tick;
            level_up <= 1'b0;

            case (st)
                IDLE: begin
                    clk_enable <= 1'b0;
                    if (start_rise) begin
                        level    <= 2'd0;
                        tick_cnt <= 8'd0;
                        speed    <= 3'b000;
                        rl_cnt   <= RL_LOAD;
                        st       <= RELOAD;
                    end
                end

                RELOAD: begin
                    if (bus.game_over) begin
                        clk_enable <= 1'b0;
                        st         <= OVER;
                    end else if (rl_cnt == '0) begin
                        clk_enable <= 1'b1;
                        st         <= RUN;
                    end else begin
                        rl_cnt <= rl_cnt - 1'b1;
                    end
                end

                RUN: begin
                    if (bus.game_over) begin
                        clk_enable <= 1'b0;
                        st         <= OVER;
                    end else begin
                        if (tick) begin
                            if (tick_cnt == TC_LAST) begin
                                tick_cnt <= 8'd0;
                                if (level < MAXL) begin
                                    level    <= level + 2'd1;
                                    speed    <= speed_of(level + 2'd1);
                                    level_up <= 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 8'd1;
                            end
                        end
                        // PAUSE disables the divider, so it doubles as the
                        // reload window when it coincides with a level-up.
                        if (pause_rise) begin
                            clk_enable <= 1'b0;
                            st         <= PAUSE;
                        end else if (tick && tick_cnt == TC_LAST && level < MAXL) begin
                            clk_enable <= 1'b0;
                            rl_cnt     <= RL_LOAD;
                            st         <= RELOAD;
                        end
                    end
                end

                PAUSE: begin
                    if (bus.game_over) begin
                        clk_enable <= 1'b0;
                        st         <= OVER;
                    end else if (pause_rise) begin
                        clk_enable <= 1'b1;
                        st         <= RUN;
                    end
                end

                OVER: begin
                    clk_enable <= 1'b0;
                    if (start_rise && !bus.game_over) begin
                        level    <= 2'd0;
                        tick_cnt <= 8'd0;
                        speed    <= 3'b000;
                        rl_cnt   <= RL_LOAD;
                        st       <= RELOAD;
                    end
                end

                default: begin
                    clk_enable <= 1'b0;
                    st         <= IDLE;
                end
            endcase
        end
    end

    assign bus.clk_enable = clk_enable;
    assign bus.speed      = speed;
    assign bus.level      = level;
    assign bus.tick_cnt   = tick_cnt;
    assign bus.level_up   = level_up;
    assign bus.state      = st;

endmodule

// File: tb/tb_game_level_ctrl.sv
// tb_game_level_ctrl
// Directed bench for game_level_ctrl with TICKS_PER_LEVEL=4, RELOAD_CYCLES=2.
module tb_game_level_ctrl;

    logic in_clk;
    logic rst_n;
    int   total;
    int   bad;

    game_level_ctrl_if bus();

    game_level_ctrl #(
        .TICKS_PER_LEVEL (4),
        .RELOAD_CYCLES   (2),
        .MAX_LEVEL       (3)
    ) dut (
        .in_clk (in_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic toggle_tick();
        bus.game_tick = ~bus.game_tick;
        cyc();
    endtask

    task automatic start_game();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        bus.game_over = 1'b0;
        bus.game_tick = 1'b0;
        #1;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
        total++; if (bus.clk_enable !== 1'b0 || bus.speed !== 3'b000 || bus.level !== 2'd0 || bus.tick_cnt !== 8'd0 || bus.level_up !== 1'b0)
            begin bad++; $display("FAIL reset_outputs en=%b speed=%b level=%0d tick=%0d up=%b want 0", bus.clk_enable, bus.speed, bus.level, bus.tick_cnt, bus.level_up); end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        total++; if (bus.state !== 3'd0 || bus.clk_enable !== 1'b0) begin bad++; $display("FAIL idle_hold state=%0d en=%b want 0/0", bus.state, bus.clk_enable); end
    endtask

    task automatic test_start();
        bus.start_btn = 1'b1;
        cyc();
        total++; if (bus.state !== 3'd1 || bus.clk_enable !== 1'b0 || bus.speed !== 3'b000) begin bad++; $display("FAIL start_reload1 state=%0d en=%b speed=%b want 1/0/000", bus.state, bus.clk_enable, bus.speed); end
        bus.start_btn = 1'b0;
        cyc();
        total++; if (bus.state !== 3'd1 || bus.clk_enable !== 1'b0) begin bad++; $display("FAIL start_reload2 state=%0d en=%b want 1/0", bus.state, bus.clk_enable); end
        cyc();
        total++; if (bus.state !== 3'd2 || bus.clk_enable !== 1'b1 || bus.level !== 2'd0) begin bad++; $display("FAIL start_run state=%0d en=%b level=%0d want 2/1/0", bus.state, bus.clk_enable, bus.level); end
    endtask

    task automatic test_tick_count();
        logic [7:0] exp_cnt [4];
        exp_cnt[0] = 8'd1; exp_cnt[1] = 8'd2; exp_cnt[2] = 8'd3; exp_cnt[3] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            toggle_tick();
            total++; if (bus.tick_cnt !== exp_cnt[i]) begin bad++; $display("FAIL tick_cnt_%0d got=%0d want=%0d", i, bus.tick_cnt, exp_cnt[i]); end
        end
        total++; if (bus.level !== 2'd1 || bus.speed !== 3'b100 || bus.level_up !== 1'b1 || bus.state !== 3'd1 || bus.clk_enable !== 1'b0)
            begin bad++; $display("FAIL level_up1 level=%0d speed=%b up=%b state=%0d en=%b want 1/100/1/1/0", bus.level, bus.speed, bus.level_up, bus.state, bus.clk_enable); end
        cyc();
        total++; if (bus.level_up !== 1'b0 || bus.state !== 3'd1 || bus.clk_enable !== 1'b0) begin bad++; $display("FAIL level_up_pulse up=%b state=%0d en=%b want 0/1/0", bus.level_up, bus.state, bus.clk_enable); end
        cyc();
        total++; if (bus.state !== 3'd2 || bus.clk_enable !== 1'b1 || bus.speed !== 3'b100) begin bad++; $display("FAIL rerun_l1 state=%0d en=%b speed=%b want 2/1/100", bus.state, bus.clk_enable, bus.speed); end
    endtask

    task automatic test_max_level();
        for (int lv = 2; lv <= 3; lv++) begin
            for (int i = 0; i < 4; i++) toggle_tick();
            cyc(2);
        end
        total++; if (bus.level !== 2'd3 || bus.speed !== 3'b001 || bus.state !== 3'd2) begin bad++; $display("FAIL reach_l3 level=%0d speed=%b state=%0d want 3/001/2", bus.level, bus.speed, bus.state); end
        for (int i = 0; i < 4; i++) begin
            toggle_tick();
            total++; if (bus.level_up !== 1'b0 || bus.state !== 3'd2 || bus.clk_enable !== 1'b1)
                begin bad++; $display("FAIL max_hold_%0d up=%b state=%0d en=%b want 0/2/1", i, bus.level_up, bus.state, bus.clk_enable); end
        end
        total++; if (bus.level !== 2'd3 || bus.tick_cnt !== 8'd0 || bus.speed !== 3'b001) begin bad++; $display("FAIL max_wrap level=%0d tick=%0d speed=%b want 3/0/001", bus.level, bus.tick_cnt, bus.speed); end
    endtask

    task automatic test_pause();
        toggle_tick();
        toggle_tick();
        bus.pause_btn = 1'b1;
        cyc();
        total++; if (bus.state !== 3'd3 || bus.clk_enable !== 1'b0 || bus.tick_cnt !== 8'd2) begin bad++; $display("FAIL pause_enter state=%0d en=%b tick=%0d want 3/0/2", bus.state, bus.clk_enable, bus.tick_cnt); end
        bus.pause_btn = 1'b0;
        for (int i = 0; i < 3; i++) toggle_tick();
        cyc();
        total++; if (bus.state !== 3'd3 || bus.tick_cnt !== 8'd2 || bus.level !== 2'd3) begin bad++; $display("FAIL pause_hold state=%0d tick=%0d level=%0d want 3/2/3", bus.state, bus.tick_cnt, bus.level); end
        bus.pause_btn = 1'b1;
        cyc();
        total++; if (bus.state !== 3'd2 || bus.clk_enable !== 1'b1 || bus.tick_cnt !== 8'd2) begin bad++; $display("FAIL pause_exit state=%0d en=%b tick=%0d want 2/1/2", bus.state, bus.clk_enable, bus.tick_cnt); end
        bus.pause_btn = 1'b0;
        cyc();
    endtask

    task automatic test_pause_threshold();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.game_tick = 1'b0;
        cyc();
        start_game();
        for (int i = 0; i < 3; i++) toggle_tick();
        total++; if (bus.tick_cnt !== 8'd3 || bus.level !== 2'd0) begin bad++; $display("FAIL pth_setup tick=%0d level=%0d want 3/0", bus.tick_cnt, bus.level); end
        bus.pause_btn = 1'b1;
        toggle_tick();
        total++; if (bus.level !== 2'd1 || bus.level_up !== 1'b1 || bus.state !== 3'd3 || bus.tick_cnt !== 8'd0 || bus.speed !== 3'b100 || bus.clk_enable !== 1'b0)
            begin bad++; $display("FAIL pth_combo level=%0d up=%b state=%0d tick=%0d speed=%b en=%b want 1/1/3/0/100/0", bus.level, bus.level_up, bus.state, bus.tick_cnt, bus.speed, bus.clk_enable); end
        bus.pause_btn = 1'b0;
        cyc();
        total++; if (bus.level_up !== 1'b0 || bus.state !== 3'd3) begin bad++; $display("FAIL pth_after up=%b state=%0d want 0/3", bus.level_up, bus.state); end
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        total++; if (bus.state !== 3'd2 || bus.clk_enable !== 1'b1 || bus.speed !== 3'b100) begin bad++; $display("FAIL pth_resume state=%0d en=%b speed=%b want 2/1/100", bus.state, bus.clk_enable, bus.speed); end
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 4; i++) toggle_tick();
        total++; if (bus.state !== 3'd1 || bus.level !== 2'd2) begin bad++; $display("FAIL go_setup state=%0d level=%0d want 1/2", bus.state, bus.level); end
        bus.game_over = 1'b1;
        cyc();
        total++; if (bus.state !== 3'd4 || bus.clk_enable !== 1'b0 || bus.level !== 2'd2) begin bad++; $display("FAIL go_reload state=%0d en=%b level=%0d want 4/0/2", bus.state, bus.clk_enable, bus.level); end
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        cyc();
        total++; if (bus.state !== 3'd4 || bus.level !== 2'd2) begin bad++; $display("FAIL go_start_ignored state=%0d level=%0d want 4/2", bus.state, bus.level); end
        bus.game_over = 1'b0;
        cyc();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        total++; if (bus.state !== 3'd1 || bus.level !== 2'd0 || bus.speed !== 3'b000 || bus.tick_cnt !== 8'd0)
            begin bad++; $display("FAIL go_restart state=%0d level=%0d speed=%b tick=%0d want 1/0/000/0", bus.state, bus.level, bus.speed, bus.tick_cnt); end
        cyc(2);
        total++; if (bus.state !== 3'd2 || bus.clk_enable !== 1'b1) begin bad++; $display("FAIL go_rerun state=%0d en=%b want 2/1", bus.state, bus.clk_enable); end
        toggle_tick();
        toggle_tick();
        bus.game_over = 1'b1;
        toggle_tick();
        total++; if (bus.state !== 3'd4 || bus.clk_enable !== 1'b0 || bus.tick_cnt !== 8'd2) begin bad++; $display("FAIL go_run_tick state=%0d en=%b tick=%0d want 4/0/2", bus.state, bus.clk_enable, bus.tick_cnt); end
        bus.game_over = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        start_game();
        toggle_tick();
        total++; if (bus.state !== 3'd2 || bus.tick_cnt !== 8'd1) begin bad++; $display("FAIL ar_setup state=%0d tick=%0d want 2/1", bus.state, bus.tick_cnt); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.state !== 3'd0 || bus.clk_enable !== 1'b0 || bus.tick_cnt !== 8'd0) begin bad++; $display("FAIL ar_midcycle state=%0d en=%b tick=%0d want 0/0/0", bus.state, bus.clk_enable, bus.tick_cnt); end
        cyc();
        rst_n = 1'b1;
        cyc();
        total++; if (bus.state !== 3'd0 || bus.level !== 2'd0) begin bad++; $display("FAIL ar_idle state=%0d level=%0d want 0/0", bus.state, bus.level); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_start();
        test_tick_count();
        test_max_level();
        test_pause();
        test_pause_threshold();
        test_game_over();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
